// File: rtl/musb_div_unit.sv
// Sequential 32-bit DIV/DIVU unit for the MUSB EX stage.
// Restoring division on magnitudes, one quotient bit per cycle, sign-corrected at the end.
module musb_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_divs,
    input  logic        op_divu,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done,
    output logic        ex_request_stall
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state;
    logic [31:0] dvd_sr;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [31:0] dvs_mag;
    logic [31:0] part_rem;   // always below the divisor, so 32 bits hold it between iterations
    logic [4:0]  count;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        start;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [32:0] rem_shift;
    logic [32:0] rem_trial;
    logic        q_bit;
    logic [31:0] rem_next;
    logic [31:0] q_mag;
    logic [31:0] q_final;
    logic [31:0] r_final;

    always_comb begin
        start            = (op_divs | op_divu) & (state == StIdle) & ~stall & ~flush;
        ex_request_stall = start | (state == StRun);

        dvd_abs = (op_divs & dividend[31]) ? (~dividend + 32'd1) : dividend;
        dvs_abs = (op_divs & divisor[31])  ? (~divisor + 32'd1)  : divisor;

        rem_shift = {part_rem, dvd_sr[31]};
        rem_trial = rem_shift - {1'b0, dvs_mag};
        q_bit     = ~rem_trial[32];
        rem_next  = q_bit ? rem_trial[31:0] : rem_shift[31:0];
        q_mag     = {dvd_sr[30:0], q_bit};

        // With a zero divisor every trial succeeds: magnitude quotient is all ones and the
        // remainder is |dividend|, which the remainder sign fix turns back into the dividend.
        if (div_zero) begin
            q_final = 32'hFFFF_FFFF;
        end else if (neg_q) begin
            q_final = ~q_mag + 32'd1;
        end else begin
            q_final = q_mag;
        end
        r_final = neg_r ? (~rem_next + 32'd1) : rem_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            dvd_sr    <= '0;
            dvs_mag   <= '0;
            part_rem  <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else if (flush) begin
            state <= StIdle;
            done  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        dvd_sr   <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        part_rem <= '0;
                        count    <= 5'd31;
                        neg_q    <= op_divs & (dividend[31] ^ divisor[31]);
                        neg_r    <= op_divs & dividend[31];
                        div_zero <= (divisor == 32'd0);
                        state    <= StRun;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        part_rem <= rem_next;
                        dvd_sr   <= q_mag;
                        count    <= count - 5'd1;
                        if (count == 5'd0) begin
                            quotient  <= q_final;
                            remainder <= r_final;
                            done      <= 1'b1;
                            state     <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Ops are still high for the retiring instruction; never restart from here.
                    if (!stall) begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_musb_div_unit.sv
// Self-checking bench for musb_div_unit: a scoreboard of expected HI/LO results checked on
// each done pulse, plus per-scenario timing and control checks.
module tb_musb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_divs = 1'b0;
    logic        op_divu = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        ex_request_stall;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_pulses = 0;
    logic [63:0] exp_q[$];
    logic        done_prev = 1'b0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    always #5 clk = ~clk;

    musb_div_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .op_divs          (op_divs),
        .op_divu          (op_divu),
        .dividend         (dividend),
        .divisor          (divisor),
        .stall            (stall),
        .flush            (flush),
        .quotient         (quotient),
        .remainder        (remainder),
        .done             (done),
        .ex_request_stall (ex_request_stall)
    );

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    // Scoreboard: every rising edge of done pops one expected result.
    always @(negedge clk) begin
        logic [63:0] e;
        if (done === 1'b1 && done_prev !== 1'b1) begin
            done_pulses++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: done=1 q=%h r=%h, required no done", quotient,
                         remainder);
            end else begin
                e = exp_q.pop_front();
                if ({quotient, remainder} !== e) begin
                    n_bad++;
                    $display("FAIL result: got q=%h r=%h, required q=%h r=%h", quotient,
                             remainder, e[63:32], e[31:0]);
                end
                last_q = e[63:32];
                last_r = e[31:0];
            end
        end
        done_prev = done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        op_divs = 1'b0;
        op_divu = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
    endtask

    // Issues one divide (cycle T) and returns in the cycle where done is seen, ops still high.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len);
        int dc;
        dc = -1;
        step();
        op_divs  = sgn;
        op_divu  = !sgn;
        dividend = a;
        divisor  = b;
        stall    = 1'b0;
        exp_q.push_back(model(sgn, a, b));
        #1;
        n_cmp++;
        if (ex_request_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL req_at_start: got %b, required 1", ex_request_stall);
        end
        for (int c = 1; c <= 100; c++) begin
            step();
            stall = (c >= stall_at) && (c < stall_at + stall_len);
            #1;
            if (done === 1'b1) begin
                dc = c;
                break;
            end
            n_cmp++;
            if (ex_request_stall !== 1'b1) begin
                n_bad++;
                $display("FAIL req_in_run: cycle T+%0d got %b, required 1", c, ex_request_stall);
            end
        end
        n_cmp++;
        if (dc != 33 + stall_len) begin
            n_bad++;
            $display("FAIL latency: done at T+%0d, required T+%0d", dc, 33 + stall_len);
        end
        n_cmp++;
        if (ex_request_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL req_in_done: got %b, required 0", ex_request_stall);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_cmp++;
        if (quotient !== 32'd0 || remainder !== 32'd0 || done !== 1'b0 ||
            ex_request_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got q=%h r=%h done=%b req=%b, required all 0", tag, quotient,
                     remainder, done, ex_request_stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        run_div(1'b0, 32'd100, 32'd7, 0, 0);
        idle();
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        idle();
    endtask

    task automatic test_signed();
        run_div(1'b1, -32'sd7, 32'd2, 0, 0);
        idle();
        run_div(1'b1, 32'd7, -32'sd2, 0, 0);
        idle();
        run_div(1'b1, -32'sd100, -32'sd9, 0, 0);
        idle();
    endtask

    task automatic test_boundaries();
        run_div(1'b0, 32'h1234_5678, 32'd0, 0, 0);
        idle();
        run_div(1'b1, 32'h1234_5678, 32'd0, 0, 0);
        idle();
        run_div(1'b1, 32'hF000_0001, 32'd0, 0, 0);
        idle();
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        idle();
        run_div(1'b0, 32'd0, 32'd17, 0, 0);
        idle();
        run_div(1'b1, 32'd0, -32'sd5, 0, 0);
        idle();
    endtask

    task automatic test_stall_run();
        run_div(1'b0, 32'hDEAD_BEEF, 32'd13, 10, 5);
        idle();
    endtask

    task automatic test_stall_done();
        int p0;
        p0 = done_pulses;
        run_div(1'b0, 32'd1000, 32'd33, 0, 0);
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            stall = (k < 3);
            #1;
            n_cmp++;
            if (done !== 1'b1 || ex_request_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL done_hold: D+%0d got done=%b req=%b, required done=1 req=0", k,
                         done, ex_request_stall);
            end
        end
        step();
        op_divu = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || ex_request_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL done_release: got done=%b req=%b, required 0 0", done,
                     ex_request_stall);
        end
        step();
        n_cmp++;
        if (done_pulses != p0 + 1) begin
            n_bad++;
            $display("FAIL done_hold_pulses: got %0d, required %0d", done_pulses, p0 + 1);
        end
    endtask

    task automatic test_flush_run();
        int p0;
        p0 = done_pulses;
        step();
        op_divu  = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        for (int c = 1; c <= 10; c++) step();
        flush = 1'b1;
        step();
        flush   = 1'b0;
        op_divu = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || ex_request_stall !== 1'b0 || quotient !== last_q ||
            remainder !== last_r) begin
            n_bad++;
            $display("FAIL flush_run: got done=%b req=%b q=%h r=%h, required 0 0 %h %h", done,
                     ex_request_stall, quotient, remainder, last_q, last_r);
        end
        for (int c = 0; c < 40; c++) step();
        n_cmp++;
        if (done_pulses != p0) begin
            n_bad++;
            $display("FAIL flush_no_done: pulses %0d, required %0d", done_pulses, p0);
        end
    endtask

    task automatic test_flush_idle();
        step();
        op_divs  = 1'b1;
        flush    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd7;
        #1;
        n_cmp++;
        if (ex_request_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle_req: got %b, required 0", ex_request_stall);
        end
        step();
        flush   = 1'b0;
        op_divs = 1'b0;
        #1;
        n_cmp++;
        if (ex_request_stall !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle_start: got req=%b done=%b, required 0 0", ex_request_stall,
                     done);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = done_pulses;
        step();
        op_divu  = 1'b1;
        dividend = 32'd999;
        divisor  = 32'd4;
        for (int c = 1; c <= 20; c++) step();
        rst_n = 1'b0;
        step();
        op_divu = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        rst_n  = 1'b1;
        last_q = '0;
        last_r = '0;
        for (int c = 0; c < 40; c++) step();
        n_cmp++;
        if (done_pulses != p0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: pulses %0d, required %0d", done_pulses, p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = done_pulses;
        run_div(1'b0, 32'd100, 32'd7, 0, 0);
        run_div(1'b0, 32'd9, 32'd3, 0, 0);
        idle();
        step();
        n_cmp++;
        if (done_pulses != p0 + 2) begin
            n_bad++;
            $display("FAIL back_to_back_pulses: got %0d, required %0d", done_pulses, p0 + 2);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        for (int i = 0; i < 8; i++) begin
            sgn = bit'($urandom_range(0, 1));
            a   = $urandom();
            b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
            if (sgn && (i % 4 == 1)) b = -b;
            run_div(sgn, a, b, 0, 0);
            idle();
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundaries();
        test_stall_run();
        test_stall_done();
        test_flush_run();
        test_flush_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_done: %0d results never produced, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
